// File: rtl/vga_window_addr_gen_if.sv
// Pixel-stream bundle between the VGA timing generator,
// the window address generator and the image RAM read port.
interface vga_window_addr_gen_if #(
  parameter int CNT_W  = 10,
  parameter int ADDR_W = 32
);

  logic [1:0]        mode;
  logic [CNT_W-1:0]  hcnt;
  logic [CNT_W-1:0]  vcnt;
  logic              hsync_in;
  logic              vsync_in;
  logic              blank_in;

  logic [ADDR_W-1:0] video_address;
  logic              in_window;
  logic              win_id;
  logic              hsync_out;
  logic              vsync_out;
  logic              blank_out;

  modport master (
    output mode,
    output hcnt,
    output vcnt,
    output hsync_in,
    output vsync_in,
    output blank_in,
    input  video_address,
    input  in_window,
    input  win_id,
    input  hsync_out,
    input  vsync_out,
    input  blank_out
  );

  modport slave (
    input  mode,
    input  hcnt,
    input  vcnt,
    input  hsync_in,
    input  vsync_in,
    input  blank_in,
    output video_address,
    output in_window,
    output win_id,
    output hsync_out,
    output vsync_out,
    output blank_out
  );

endinterface

// File: rtl/vga_window_addr_gen.sv
// Pipelined frame-buffer address generator mapping hcnt/vcnt
// into one or two image windows, with aligned sync/blank.
module vga_window_addr_gen #(
  parameter int unsigned CNT_W  = 10,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned IMG_W  = 256,
  parameter int unsigned IMG_H  = 256,
  parameter int unsigned WIN0_X = 40,
  parameter int unsigned WIN1_X = 344,
  parameter int unsigned WIN_Y  = 112,
  parameter logic [ADDR_W-1:0] IMG0_BASE  = 'h0,
  parameter logic [ADDR_W-1:0] IMG1_BASE  = 'h10000,
  parameter logic [ADDR_W-1:0] BLACK_ADDR = 'h20000,
  parameter int unsigned PIPE   = 2
) (
  input logic clk,
  input logic rst,
  vga_window_addr_gen_if.slave bus
);

  localparam int unsigned W0_L = WIN0_X;
  localparam int unsigned W0_R = WIN0_X + IMG_W;
  localparam int unsigned W1_L = WIN1_X;
  localparam int unsigned W1_R = WIN1_X + IMG_W;
  localparam int unsigned Y_T  = WIN_Y;
  localparam int unsigned Y_B  = WIN_Y + IMG_H;

  // sync bundle: {hsync, vsync, blank}
  localparam logic [2:0] SYNC_RST = 3'b001;

  typedef struct packed {
    logic              hit;
    logic              id;
    logic [CNT_W-1:0]  ix;
    logic [CNT_W-1:0]  iy;
    logic [ADDR_W-1:0] base;
  } s1_t;

  logic [1:0]  mode_q;
  logic [1:0]  mode_eff;
  logic        frame_start;
  logic [31:0] h32;
  logic [31:0] v32;
  logic        y_hit;
  logic        hit0;
  logic        hit1;

  s1_t s1_d;
  s1_t s1_q;

  logic [ADDR_W-1:0] addr_d;

  logic [ADDR_W-1:0] addr_p [0:PIPE-2];
  logic              win_p  [0:PIPE-2];
  logic              id_p   [0:PIPE-2];
  logic [2:0]        sync_p [0:PIPE-1];

  // frame start loads the new mode and uses it on that same pixel
  always_comb begin
    frame_start = (bus.hcnt == '0) && (bus.vcnt == '0);
    mode_eff    = frame_start ? bus.mode : mode_q;
  end

  // mode shadow, only updated on the first pixel of a frame
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= 2'b00;
    end else if (frame_start) begin
      mode_q <= bus.mode;
    end
  end

  // window hit tests with exclusive right/bottom edges
  always_comb begin
    h32   = 32'(bus.hcnt);
    v32   = 32'(bus.vcnt);
    y_hit = (v32 >= Y_T) && (v32 < Y_B);
    hit0  = y_hit && (h32 >= W0_L) && (h32 < W0_R);
    hit1  = mode_eff[1] && y_hit
         && (h32 >= W1_L) && (h32 < W1_R);
  end

  // stage-1 next state: hit, window id, offsets, image base
  always_comb begin
    s1_d      = '0;
    s1_d.base = IMG0_BASE;
    unique case (1'b1)
      hit0: begin
        s1_d.hit  = 1'b1;
        s1_d.id   = 1'b0;
        s1_d.ix   = bus.hcnt - CNT_W'(WIN0_X);
        s1_d.iy   = bus.vcnt - CNT_W'(WIN_Y);
        s1_d.base = mode_eff[0] ? IMG1_BASE : IMG0_BASE;
      end
      hit1: begin
        s1_d.hit  = 1'b1;
        s1_d.id   = 1'b1;
        s1_d.ix   = bus.hcnt - CNT_W'(WIN1_X);
        s1_d.iy   = bus.vcnt - CNT_W'(WIN_Y);
        s1_d.base = mode_eff[0] ? IMG0_BASE : IMG1_BASE;
      end
      default: begin
        s1_d.hit  = 1'b0;
      end
    endcase
  end

  // stage-1 register
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= '0;
      s1_q.base <= IMG0_BASE;
    end else begin
      s1_q <= s1_d;
    end
  end

  // stage-2 address: base + row*IMG_W + column, or border
  always_comb begin
    addr_d = BLACK_ADDR;
    if (s1_q.hit) begin
      addr_d = s1_q.base
             + ADDR_W'(s1_q.iy) * ADDR_W'(IMG_W)
             + ADDR_W'(s1_q.ix);
    end
  end

  // stage-2 register followed by pure delay stages
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= int'(PIPE) - 2; k++) begin
        addr_p[k] <= BLACK_ADDR;
        win_p[k]  <= 1'b0;
        id_p[k]   <= 1'b0;
      end
    end else begin
      addr_p[0] <= addr_d;
      win_p[0]  <= s1_q.hit;
      id_p[0]   <= s1_q.id;
      for (int k = 1; k <= int'(PIPE) - 2; k++) begin
        addr_p[k] <= addr_p[k-1];
        win_p[k]  <= win_p[k-1];
        id_p[k]   <= id_p[k-1];
      end
    end
  end

  // sync/blank shift register matching the address latency
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= int'(PIPE) - 1; k++) begin
        sync_p[k] <= SYNC_RST;
      end
    end else begin
      sync_p[0] <= {bus.hsync_in, bus.vsync_in, bus.blank_in};
      for (int k = 1; k <= int'(PIPE) - 1; k++) begin
        sync_p[k] <= sync_p[k-1];
      end
    end
  end

  assign bus.video_address = addr_p[PIPE-2];
  assign bus.in_window     = win_p[PIPE-2];
  assign bus.win_id        = id_p[PIPE-2];
  assign bus.hsync_out     = sync_p[PIPE-1][2];
  assign bus.vsync_out     = sync_p[PIPE-1][1];
  assign bus.blank_out     = sync_p[PIPE-1][0];

endmodule

// File: tb/tb_vga_window_addr_gen.sv
// Directed bench for vga_window_addr_gen, run side by side
// at PIPE=2 and PIPE=4 with identical stimulus.
module tb_vga_window_addr_gen;

  localparam logic [31:0] BLK = 32'h20000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  vga_window_addr_gen_if #(.CNT_W(10), .ADDR_W(32)) b2 ();
  vga_window_addr_gen_if #(.CNT_W(10), .ADDR_W(32)) b4 ();

  vga_window_addr_gen #(.PIPE(2)) u_p2 (
    .clk (clk),
    .rst (rst),
    .bus (b2)
  );

  vga_window_addr_gen #(.PIPE(4)) u_p4 (
    .clk (clk),
    .rst (rst),
    .bus (b4)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [9:0] h, input logic [9:0] v,
                       input logic hs, input logic vs,
                       input logic bl);
    b2.hcnt = h;  b4.hcnt = h;
    b2.vcnt = v;  b4.vcnt = v;
    b2.hsync_in = hs;  b4.hsync_in = hs;
    b2.vsync_in = vs;  b4.vsync_in = vs;
    b2.blank_in = bl;  b4.blank_in = bl;
  endtask

  task automatic set_mode(input logic [1:0] m);
    b2.mode = m;
    b4.mode = m;
  endtask

  task automatic idle();
    drive(10'd799, 10'd524, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_start(input logic [1:0] m);
    set_mode(m);
    drive(10'd0, 10'd0, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
  endtask

  // one pixel, then idle; checks exact latency at PIPE 2 and 4
  task automatic apply(input string tag,
                       input logic [9:0] h, input logic [9:0] v,
                       input logic [31:0] ea,
                       input logic ein, input logic eid);
    drive(h, v, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    tick();
    check({tag, "/p2.addr"}, b2.video_address, ea);
    check({tag, "/p2.inw"}, 32'(b2.in_window), 32'(ein));
    check({tag, "/p2.id"}, 32'(b2.win_id), 32'(eid));
    tick();
    check({tag, "/p2.drain"}, b2.video_address, BLK);
    tick();
    check({tag, "/p4.addr"}, b4.video_address, ea);
    check({tag, "/p4.inw"}, 32'(b4.in_window), 32'(ein));
    check({tag, "/p4.id"}, 32'(b4.win_id), 32'(eid));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "/p2.addr"}, b2.video_address, BLK);
    check({tag, "/p2.inw"}, 32'(b2.in_window), 32'd0);
    check({tag, "/p2.id"}, 32'(b2.win_id), 32'd0);
    check({tag, "/p2.hs"}, 32'(b2.hsync_out), 32'd0);
    check({tag, "/p2.vs"}, 32'(b2.vsync_out), 32'd0);
    check({tag, "/p2.bl"}, 32'(b2.blank_out), 32'd1);
    check({tag, "/p4.addr"}, b4.video_address, BLK);
    check({tag, "/p4.hs"}, 32'(b4.hsync_out), 32'd0);
    check({tag, "/p4.bl"}, 32'(b4.blank_out), 32'd1);
  endtask

  initial begin
    set_mode(2'b00);
    idle();

    // reset held 3 clocks with random inputs
    for (int i = 0; i < 3; i++) begin
      drive(10'($urandom_range(0, 1023)),
            10'($urandom_range(0, 1023)),
            1'($urandom), 1'($urandom), 1'($urandom));
      tick();
      check_reset_state("rst");
    end
    rst = 1'b0;
    idle();

    // shadow still 00: win1 ignored without a frame start
    set_mode(2'b10);
    apply("rst_shadow", 10'd344, 10'd112, BLK, 1'b0, 1'b0);
    apply("rst_resume", 10'd40, 10'd112, 32'h0, 1'b1, 1'b0);

    // mode 00
    frame_start(2'b00);
    apply("m00_tl", 10'd40, 10'd112, 32'h0, 1'b1, 1'b0);
    apply("m00_br", 10'd295, 10'd367, 32'hFFFF, 1'b1, 1'b0);
    apply("m00_redge", 10'd296, 10'd200, BLK, 1'b0, 1'b0);
    apply("m00_nowin1", 10'd344, 10'd112, BLK, 1'b0, 1'b0);
    apply("m00_offscr", 10'd1000, 10'd1000, BLK, 1'b0, 1'b0);

    // mode 10
    frame_start(2'b10);
    apply("m10_w1", 10'd344, 10'd113, 32'h10100, 1'b1, 1'b1);
    apply("m10_ledge", 10'd343, 10'd113, BLK, 1'b0, 1'b0);
    apply("m10_bedge", 10'd344, 10'd368, BLK, 1'b0, 1'b0);
    apply("m10_w0", 10'd40, 10'd112, 32'h0, 1'b1, 1'b0);
    apply("m10_w1br", 10'd599, 10'd367, 32'h1FFFF, 1'b1, 1'b1);
    apply("m10_w1redge", 10'd600, 10'd200, BLK, 1'b0, 1'b0);

    // mode 11
    frame_start(2'b11);
    apply("m11_w0", 10'd40, 10'd112, 32'h10000, 1'b1, 1'b0);
    apply("m11_w1", 10'd344, 10'd112, 32'h0, 1'b1, 1'b1);

    // mid-frame change is deferred to the next frame start
    frame_start(2'b00);
    set_mode(2'b01);
    drive(10'd100, 10'd200, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    apply("mid_old", 10'd40, 10'd201, 32'h5900, 1'b1, 1'b0);
    frame_start(2'b01);
    apply("mid_new", 10'd40, 10'd201, 32'h15900, 1'b1, 1'b0);

    // alignment of sync/blank with the address (mode 01)
    drive(10'd40, 10'd112, 1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) idle();
      check($sformatf("algn%0d/p2.hs", k),
            32'(b2.hsync_out), 32'(k == 2));
      check($sformatf("algn%0d/p2.vs", k),
            32'(b2.vsync_out), 32'(k == 2));
      check($sformatf("algn%0d/p2.bl", k),
            32'(b2.blank_out), 32'(k != 2));
      check($sformatf("algn%0d/p2.addr", k),
            b2.video_address, (k == 2) ? 32'h10000 : BLK);
      check($sformatf("algn%0d/p4.hs", k),
            32'(b4.hsync_out), 32'(k == 4));
      check($sformatf("algn%0d/p4.bl", k),
            32'(b4.blank_out), 32'(k != 4));
      check($sformatf("algn%0d/p4.addr", k),
            b4.video_address, (k == 4) ? 32'h10000 : BLK);
    end

    // reset mid-frame clears outputs and the mode shadow
    frame_start(2'b11);
    drive(10'd40, 10'd112, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    rst = 1'b1;
    tick();
    check_reset_state("midrst");
    rst = 1'b0;
    apply("midrst_m00", 10'd40, 10'd112, 32'h0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
